// File: rtl/spart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spart_tx_ctrl
// Description : Bus-side controller for the SPART transmit path. Decodes
//               processor I/O accesses, holds the baud divisor, generates the
//               per-bit tx_enable tick, buffers bytes in a small FIFO and
//               sequences the TX shifter through its write/tbr handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_tx_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd5207
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       tx_enable,
  output logic       tx_write,
  output logic [7:0] tx_data,
  input  logic       tbr,
  output logic       irq_tx_empty
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t      state_q;
  logic        tx_write_q;
  logic [7:0]  tx_data_q;
  logic [7:0]  rd_data_q;
  logic        ovr_q;
  logic [15:0] div_q;
  logic [15:0] div_d;
  logic [15:0] baud_q;
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic [7:0]  mem_q [FIFO_DEPTH];

  // Bus decode
  logic wr_acc;
  logic rd_acc;
  logic push;
  logic div_lo_wr;
  logic div_hi_wr;
  logic div_load;

  assign wr_acc    = iocs & ~iorw;
  assign rd_acc    = iocs &  iorw;
  assign push      = wr_acc & (ioaddr == ADDR_DATA);
  assign div_lo_wr = wr_acc & (ioaddr == ADDR_DIV_LO);
  assign div_hi_wr = wr_acc & (ioaddr == ADDR_DIV_HI);
  assign div_load  = div_lo_wr | div_hi_wr;

  // FIFO status: equal index with differing wrap bit means full
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push_ok;
  logic       ovr_set;
  logic [7:0] fifo_head;
  logic [7:0] status_byte;

  assign fifo_empty  = (wptr_q == rptr_q);
  assign fifo_full   = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop         = (state_q == ST_IDLE) && !fifo_empty && tbr;
  // A pop in the same cycle frees the slot, so a push into a full FIFO lands.
  assign push_ok     = push && (!fifo_full || pop);
  assign ovr_set     = push && fifo_full && !pop;
  assign fifo_head   = mem_q[rptr_q[AW-1:0]];

  assign irq_tx_empty = fifo_empty && (state_q == ST_IDLE) && tbr;
  assign status_byte  = {5'b0, ovr_q, irq_tx_empty, ~fifo_full};

  // Next divisor value with the addressed byte replaced
  always_comb begin
    div_d = div_q;
    if (div_lo_wr) div_d[7:0]  = wr_data;
    if (div_hi_wr) div_d[15:8] = wr_data;
  end

  // Divisor register and free-running baud down counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= DIV_RESET;
      baud_q <= DIV_RESET;
    end else begin
      div_q <= div_d;
      if (div_load) begin
        baud_q <= div_d;
      end else if (baud_q == 16'd0) begin
        baud_q <= div_q;
      end else begin
        baud_q <= baud_q - 16'd1;
      end
    end
  end

  assign tx_enable = (baud_q == 16'd0);

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data;
    end
  end

  // FIFO read/write pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_ONE;
      if (pop)     rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Registered read data and sticky overrun flag (a new overrun beats a clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= 8'h00;
      ovr_q     <= 1'b0;
    end else begin
      if (rd_acc) begin
        case (ioaddr)
          ADDR_DATA:   rd_data_q <= 8'h00;
          ADDR_STATUS: rd_data_q <= status_byte;
          ADDR_DIV_LO: rd_data_q <= div_q[7:0];
          ADDR_DIV_HI: rd_data_q <= div_q[15:8];
          default:     rd_data_q <= 8'h00;
        endcase
      end
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end else if (rd_acc && (ioaddr == ADDR_STATUS)) begin
        ovr_q <= 1'b0;
      end
    end
  end

  // Shifter sequencer: pop, hold write until accepted, wait for idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tx_write_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            tx_data_q  <= fifo_head;
            tx_write_q <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // A tbr glitch high here is ignored; only an accept (tbr=0) moves on.
          if (!tbr) begin
            tx_write_q <= 1'b0;
            state_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (tbr) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_write_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_data  = rd_data_q;
  assign tx_write = tx_write_q;
  assign tx_data  = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spart_tx_ctrl
// Description : Self-checking bench for spart_tx_ctrl with an attached TX
//               shifter model and a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_tx_ctrl;

  localparam int          DEPTH   = 4;
  localparam logic [15:0] DIV_RST = 16'd5207;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       tx_enable;
  logic       tx_write;
  logic [7:0] tx_data;
  logic       tbr = 1'b1;
  logic       irq_tx_empty;

  int n_checks = 0;
  int n_fail   = 0;

  spart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIV_RST)) dut (
    .clk          (clk),
    .rst          (rst),
    .iocs         (iocs),
    .iorw         (iorw),
    .ioaddr       (ioaddr),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .tx_enable    (tx_enable),
    .tx_write     (tx_write),
    .tx_data      (tx_data),
    .tbr          (tbr),
    .irq_tx_empty (irq_tx_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (state after the most recent edge) -----
  logic [15:0] m_div = DIV_RST;
  logic [15:0] m_cnt = DIV_RST;
  logic [7:0]  m_q[$];
  logic        m_ovr = 1'b0;
  logic        m_pres = 1'b0;   // byte presented to shifter, not yet accepted
  logic        m_fly = 1'b0;    // shifter has the byte, frame not finished
  logic [7:0]  m_txd = 8'h00;
  logic [7:0]  m_rd = 8'h00;

  initial begin : model
    logic push, rd, full, pop, irq;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_div = DIV_RST; m_cnt = DIV_RST; m_q.delete(); m_ovr = 1'b0;
        m_pres = 1'b0; m_fly = 1'b0; m_txd = 8'h00; m_rd = 8'h00;
      end
      irq = (m_q.size() == 0) && !m_pres && !m_fly && tbr;
      chk("tx_enable", {31'b0, tx_enable}, {31'b0, m_cnt == 16'd0});
      chk("tx_write", {31'b0, tx_write}, {31'b0, m_pres});
      chk("tx_data", {24'b0, tx_data}, {24'b0, m_txd});
      chk("rd_data", {24'b0, rd_data}, {24'b0, m_rd});
      chk("irq_tx_empty", {31'b0, irq_tx_empty}, {31'b0, irq});
      if (rst) begin
        full = (m_q.size() == DEPTH);
        push = iocs && !iorw && (ioaddr == 2'd0);
        rd   = iocs && iorw;
        pop  = !m_pres && !m_fly && (m_q.size() > 0) && tbr;
        if (rd) begin
          case (ioaddr)
            2'd0: m_rd = 8'h00;
            2'd1: m_rd = {5'b0, m_ovr, irq, !full};
            2'd2: m_rd = m_div[7:0];
            default: m_rd = m_div[15:8];
          endcase
        end
        if (push && full && !pop) m_ovr = 1'b1;
        else if (rd && ioaddr == 2'd1) m_ovr = 1'b0;
        if (pop) begin
          m_txd = m_q.pop_front();
          m_pres = 1'b1;
        end else if (m_pres && !tbr) begin
          m_pres = 1'b0; m_fly = 1'b1;
        end else if (m_fly && tbr) begin
          m_fly = 1'b0;
        end
        if (push && m_q.size() < DEPTH) m_q.push_back(wr_data);
        if (iocs && !iorw && ioaddr[1]) begin
          if (ioaddr[0]) m_div[15:8] = wr_data;
          else           m_div[7:0]  = wr_data;
          m_cnt = m_div;
        end else if (m_cnt == 16'd0) begin
          m_cnt = m_div;
        end else begin
          m_cnt = m_cnt - 16'd1;
        end
      end
    end
  end

  // ---------------- TX shifter model: loads on a tick while tx_write=1 ----
  logic       sh_busy = 1'b0;
  logic       txd = 1'b1;
  logic       bitlog[$];
  logic [7:0] sent[$];

  initial begin : shifter
    logic en, wr;
    logic [7:0] d;
    logic [9:0] frame, got;
    int idx;
    idx = 0; frame = '0; got = '0;
    forever begin
      @(negedge clk);
      en = tx_enable; wr = tx_write; d = tx_data;
      @(posedge clk);
      #1;
      if (!rst) begin
        sh_busy = 1'b0; tbr = 1'b1; txd = 1'b1;
      end else if (en) begin
        if (!sh_busy) begin
          if (wr) begin
            sh_busy = 1'b1; frame = {1'b1, d, 1'b0}; idx = 0;
            txd = frame[0]; got[0] = txd; bitlog.push_back(txd); tbr = 1'b0;
          end
        end else begin
          idx++;
          if (idx == 10) begin
            sh_busy = 1'b0; tbr = 1'b1; txd = 1'b1;
            chk("frame_byte", {24'b0, got[8:1]}, {24'b0, m_txd});
            sent.push_back(got[8:1]);
          end else begin
            txd = frame[idx]; got[idx] = txd; bitlog.push_back(txd);
          end
        end
      end
    end
  end

  // ---------------- bus helpers -------------------------------------------
  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; wr_data = d;
  endtask

  task automatic bus_idle();
    @(posedge clk); #2;
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] v);
    @(posedge clk); #2;
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    @(posedge clk); #2;
    iocs = 1'b0; iorw = 1'b0;
    v = rd_data;
  endtask

  task automatic measure_period(input int bound, output int period);
    int c, t0;
    c = 0; t0 = -1; period = -1;
    while (c < bound) begin
      @(negedge clk);
      c++;
      if (tx_enable) begin
        if (t0 < 0) t0 = c;
        else begin
          period = c - t0;
          break;
        end
      end
    end
  endtask

  task automatic wait_sent(input int n, input int bound, input string name);
    int c;
    c = 0;
    while (sent.size() < n && c < bound) begin
      @(posedge clk); #2;
      c++;
    end
    chk(name, {31'b0, sent.size() >= n}, 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus -----------------------------------------
  initial begin : stim
    logic [7:0] v;
    logic [7:0] exp_sent[6];
    logic       exp_bits[10];
    int p, c, cnt;

    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_irq", {31'b0, irq_tx_empty}, 32'd1);
    chk("reset_tx_write", {31'b0, tx_write}, 32'd0);
    chk("reset_rd_data", {24'b0, rd_data}, 32'd0);

    measure_period(12000, p);
    chk("reset_tick_period", p, DIV_RST + 1);
    bus_rd(2'd1, v);
    chk("status_after_reset", {24'b0, v}, 32'h03);

    // Divisor 3, then one byte followed by a burst that overflows the FIFO
    bus_wr(2'd2, 8'h03);
    bus_wr(2'd3, 8'h00);
    bitlog.delete();
    bus_wr(2'd0, 8'h22);
    for (int i = 0; i < 5; i++) bus_wr(2'd0, 8'hA1 + 8'(i));
    bus_idle();
    measure_period(20, p);
    chk("div3_tick_period", p, 4);
    bus_rd(2'd1, v);
    chk("status_overrun", {24'b0, v}, 32'h04);
    bus_rd(2'd1, v);
    chk("status_overrun_cleared", {24'b0, v}, 32'h00);

    // Push into a full FIFO on the very cycle the sequencer pops
    c = 0;
    do begin
      @(posedge clk); #2;
      c++;
    end while (!(!m_pres && !m_fly && m_q.size() == DEPTH && tbr) && c < 2000);
    chk("pop_while_full_found", {31'b0, c < 2000}, 32'd1);
    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'd0; wr_data = 8'hB5;
    bus_idle();
    bus_rd(2'd1, v);
    chk("status_push_pop_full", {24'b0, v}, 32'h00);

    wait_sent(6, 3000, "burst_sent_timeout");
    exp_sent = '{8'h22, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB5};
    for (int i = 0; i < 6; i++)
      chk($sformatf("sent_byte_%0d", i), (i < sent.size()) ? {24'b0, sent[i]} : 32'hdead, {24'b0, exp_sent[i]});
    exp_bits = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++)
      chk($sformatf("txd_bit_%0d", i), (i < bitlog.size()) ? {31'b0, bitlog[i]} : 32'hdead, {31'b0, exp_bits[i]});
    chk("txd_stop_line", {31'b0, (bitlog.size() > 9) ? bitlog[9] : 1'bx}, {31'b0, exp_bits[9]});
    repeat (4) @(posedge clk);
    #2;
    chk("irq_after_drain", {31'b0, irq_tx_empty}, 32'd1);
    bus_rd(2'd1, v);
    chk("status_after_drain", {24'b0, v}, 32'h03);

    // Reset while a frame is in flight
    bus_wr(2'd0, 8'h3C);
    bus_idle();
    c = 0;
    while (!m_fly && c < 200) begin
      @(posedge clk); #2;
      c++;
    end
    chk("frame_started", {31'b0, m_fly}, 32'd1);
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_reset_tx_write", {31'b0, tx_write}, 32'd0);
    chk("async_reset_tx_enable", {31'b0, tx_enable}, 32'd0);
    chk("async_reset_rd_data", {24'b0, rd_data}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    bus_rd(2'd2, v);
    chk("div_lo_after_reset", {24'b0, v}, 32'h57);
    bus_rd(2'd3, v);
    chk("div_hi_after_reset", {24'b0, v}, 32'h14);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_write) cnt++;
    end
    chk("no_tx_write_after_reset", cnt, 0);
    chk("inflight_byte_lost", sent.size(), 6);

    // Divisor zero: tick every cycle, one frame in ten ticks
    bus_wr(2'd2, 8'h00);
    bus_wr(2'd3, 8'h00);
    bus_idle();
    measure_period(10, p);
    chk("div0_tick_period", p, 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_enable) cnt++;
    end
    chk("div0_tick_count", cnt, 12);
    bus_wr(2'd0, 8'h5A);
    bus_idle();
    wait_sent(7, 200, "div0_frame_timeout");
    chk("div0_frame_byte", (sent.size() > 6) ? {24'b0, sent[6]} : 32'hdead, 32'h5A);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
